// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF spiking inference core.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HID  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int LEAK_W = 4;

  // Signed add clipped to a w-bit two's-complement range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end else begin
      return s;
    end
  endfunction

  // Flat weight address of source i feeding neuron n of the hidden or output layer.
  function automatic int weight_addr(input bit is_out, input int n, input int i,
                                     input int n_in, input int n_hid);
    if (is_out) begin
      return n_hid * (n_in + 1) + n * (n_hid + 1) + i;
    end else begin
      return n * (n_in + 1) + i;
    end
  endfunction

endpackage

// File: rtl/snn_lif_array_if.sv
// Run control, configuration, weight-load and result bundle of snn_lif_array.
interface snn_lif_array_if #(
  parameter int N_IN   = 2,
  parameter int N_HID  = 4,
  parameter int N_OUT  = 2,
  parameter int WGT_W  = 8,
  parameter int STEP_W = 9,
  parameter int CNT_W  = 8,
  parameter int AW     = $clog2(N_HID * (N_IN + 1) + N_OUT * (N_HID + 1))
);
  logic                    start;
  logic [N_IN-1:0]         inputs;
  logic [STEP_W-1:0]       cfg_steps;
  logic [3:0]              cfg_leak;
  logic                    w_we;
  logic [AW-1:0]           w_addr;
  logic [WGT_W-1:0]        w_data;
  logic                    busy;
  logic                    done;
  logic [N_OUT*CNT_W-1:0]  spike_count;

  modport master (output start, inputs, cfg_steps, cfg_leak, w_we, w_addr, w_data,
                  input  busy, done, spike_count);
  modport slave  (input  start, inputs, cfg_steps, cfg_leak, w_we, w_addr, w_data,
                  output busy, done, spike_count);
endinterface

// File: rtl/snn_lif_neuron.sv
// One leaky integrate-and-fire neuron: leak, weighted accumulate, threshold, reset-on-fire.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int N_SRC  = 2,
  parameter int WGT_W  = 8,
  parameter int MEM_W  = 16,
  parameter int THRESH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic [LEAK_W-1:0]       leak,
  input  logic [N_SRC-1:0]        src,
  input  logic [N_SRC*WGT_W-1:0]  wgt,
  input  logic signed [WGT_W-1:0] bias,
  output logic                    spike
);
  localparam int SUM_W = MEM_W + 4;
  localparam logic signed [MEM_W-1:0] THRESH_M = MEM_W'(THRESH);

  logic signed [MEM_W-1:0] v_r;
  logic signed [SUM_W-1:0] v_ext_s;
  logic signed [SUM_W-1:0] leaked_s;
  logic signed [SUM_W-1:0] syn_s;
  logic signed [MEM_W-1:0] v_next_s;
  logic                    fire_s;

  // Candidate membrane value for this update and the firing decision.
  always_comb begin
    v_ext_s  = SUM_W'(v_r);
    leaked_s = v_ext_s - (v_ext_s >>> leak);
    syn_s    = SUM_W'(bias);
    for (int i = 0; i < N_SRC; i++) begin
      if (src[i]) begin
        syn_s = syn_s + SUM_W'($signed(wgt[i*WGT_W +: WGT_W]));
      end else begin
        syn_s = syn_s;
      end
    end
    v_next_s = MEM_W'(sat_add(32'(leaked_s), 32'(syn_s), MEM_W));
    fire_s   = (v_next_s >= THRESH_M);
  end

  // Membrane and spike registers; only the owning phase advances them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_r   <= {MEM_W{1'b0}};
      spike <= 1'b0;
    end else if (clr) begin
      v_r   <= {MEM_W{1'b0}};
      spike <= 1'b0;
    end else if (en) begin
      spike <= fire_s;
      v_r   <= fire_s ? {MEM_W{1'b0}} : v_next_s;
    end
  end

endmodule

// File: rtl/snn_lif_array.sv
// Two-layer LIF inference core: weight file, phase FSM, timestep counter, output spike counters.
module snn_lif_array
  import snn_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_HID  = 4,
  parameter int N_OUT  = 2,
  parameter int WGT_W  = 8,
  parameter int MEM_W  = 16,
  parameter int THRESH = 8,
  parameter int STEP_W = 9,
  parameter int CNT_W  = 8,
  parameter int AW     = $clog2(N_HID * (N_IN + 1) + N_OUT * (N_HID + 1))
) (
  input  logic             clk,
  input  logic             reset,
  snn_lif_array_if.slave   bus
);
  localparam int NW = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);

  state_t                  state_r, state_nx_s;
  logic [STEP_W-1:0]       t_r, steps_r;
  logic [LEAK_W-1:0]       leak_r;
  logic [N_IN-1:0]         in_r;
  logic signed [WGT_W-1:0] wgt_r [NW];
  logic                    busy_r, done_r;
  logic [CNT_W-1:0]        cnt_r [N_OUT];
  logic [N_HID-1:0]        h_spike_s;
  logic [N_OUT-1:0]        o_spike_s;
  logic                    start_s, last_s, hid_en_s, out_en_s, w_ok_s;

  assign start_s  = (state_r == IDLE) && bus.start;
  assign hid_en_s = (state_r == HID);
  assign out_en_s = (state_r == OUT);
  assign last_s   = ({1'b0, t_r} + {{STEP_W{1'b0}}, 1'b1}) >= {1'b0, steps_r};
  assign w_ok_s   = bus.w_we && (state_r == IDLE) && !busy_r &&
                    ({{(32-AW){1'b0}}, bus.w_addr} < 32'(NW));

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx_s = (bus.cfg_steps == {STEP_W{1'b0}}) ? DONE : HID;
        end else begin
          state_nx_s = IDLE;
        end
      end
      HID:     state_nx_s = OUT;
      OUT:     state_nx_s = last_s ? DONE : HID;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, run configuration latch, timestep counter and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      t_r     <= {STEP_W{1'b0}};
      steps_r <= {STEP_W{1'b0}};
      leak_r  <= {LEAK_W{1'b0}};
      in_r    <= {N_IN{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= (state_r == DONE);
      if (start_s) begin
        t_r     <= {STEP_W{1'b0}};
        steps_r <= bus.cfg_steps;
        leak_r  <= bus.cfg_leak;
        in_r    <= bus.inputs;
        busy_r  <= 1'b1;
      end else if (state_r == DONE) begin
        busy_r  <= 1'b0;
      end else if (out_en_s && !last_s) begin
        t_r     <= t_r + {{(STEP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Weight register file, loadable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < NW; a++) wgt_r[a] <= {WGT_W{1'b0}};
    end else if (w_ok_s) begin
      wgt_r[bus.w_addr] <= bus.w_data;
    end
  end

  // An output spike registered in OUT is counted on the following edge (HID or DONE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) cnt_r[k] <= {CNT_W{1'b0}};
    end else if (start_s) begin
      for (int k = 0; k < N_OUT; k++) cnt_r[k] <= {CNT_W{1'b0}};
    end else if ((state_r == HID) || (state_r == DONE)) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (o_spike_s[k] && (cnt_r[k] != {CNT_W{1'b1}})) begin
          cnt_r[k] <= cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;

  for (genvar j = 0; j < N_HID; j++) begin : g_hid
    localparam int AB = weight_addr(1'b0, j, N_IN, N_IN, N_HID);
    logic [N_IN*WGT_W-1:0] w_s;
    for (genvar i = 0; i < N_IN; i++) begin : g_w
      localparam int A = weight_addr(1'b0, j, i, N_IN, N_HID);
      assign w_s[i*WGT_W +: WGT_W] = wgt_r[A];
    end
    snn_lif_neuron #(.N_SRC(N_IN), .WGT_W(WGT_W), .MEM_W(MEM_W), .THRESH(THRESH)) u_neuron (
      .clk(clk), .reset(reset), .clr(start_s), .en(hid_en_s), .leak(leak_r),
      .src(in_r), .wgt(w_s), .bias(wgt_r[AB]), .spike(h_spike_s[j])
    );
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    localparam int AB = weight_addr(1'b1, k, N_HID, N_IN, N_HID);
    logic [N_HID*WGT_W-1:0] w_s;
    for (genvar i = 0; i < N_HID; i++) begin : g_w
      localparam int A = weight_addr(1'b1, k, i, N_IN, N_HID);
      assign w_s[i*WGT_W +: WGT_W] = wgt_r[A];
    end
    snn_lif_neuron #(.N_SRC(N_HID), .WGT_W(WGT_W), .MEM_W(MEM_W), .THRESH(THRESH)) u_neuron (
      .clk(clk), .reset(reset), .clr(start_s), .en(out_en_s), .leak(leak_r),
      .src(h_spike_s), .wgt(w_s), .bias(wgt_r[AB]), .spike(o_spike_s[k])
    );
    assign bus.spike_count[k*CNT_W +: CNT_W] = cnt_r[k];
  end

endmodule
